// File: rtl/cms_trace_packetizer.sv
// Trace packetizer: captures committed {instr, pc} pairs into a FWFT FIFO and streams them on AXI-Stream.
// Optional macro CMS_TIMESTAMP_EN adds a free-running 32-bit capture timestamp to every packet.
module cms_trace_packetizer #(
  parameter int XLEN = 64,
`ifdef CMS_TIMESTAMP_EN
  parameter int AXI_DATA_WIDTH = XLEN + 64,
`else
  parameter int AXI_DATA_WIDTH = XLEN + 32,
`endif
  parameter int FIFO_DEPTH = 16,
  parameter int CTRL_ADDR_WIDTH = 8,
  parameter int CTRL_DATA_WIDTH = 64,
  parameter int CTRL_WRITE_ENABLE_POSEDGE_TRIGGERED = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [31:0]                        instr,
  input  logic [XLEN-1:0]                    pc,
  input  logic                               pc_valid,
  output logic                               M_AXIS_tvalid,
  input  logic                               M_AXIS_tready,
  output logic [AXI_DATA_WIDTH-1:0]          M_AXIS_tdata,
  output logic                               M_AXIS_tlast,
  input  logic [CTRL_ADDR_WIDTH-1:0]         ctrl_addr,
  input  logic [CTRL_DATA_WIDTH-1:0]         ctrl_wdata,
  input  logic                               ctrl_write_enable,
  output logic [31:0]                        overflow_count,
  output logic [$clog2(FIFO_DEPTH):0]        fifo_level
);

`ifdef CMS_TIMESTAMP_EN
  localparam int PKT_W = XLEN + 64;
`else
  localparam int PKT_W = XLEN + 32;
`endif
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [1:0] ST_DISABLED   = 2'd0;
  localparam logic [1:0] ST_WAIT_START = 2'd1;
  localparam logic [1:0] ST_CAPTURING  = 2'd2;
  localparam logic [1:0] ST_DRAINING   = 2'd3;

  localparam logic [CTRL_ADDR_WIDTH-1:0] ADDR_CTRL     = CTRL_ADDR_WIDTH'(8'h00);
  localparam logic [CTRL_ADDR_WIDTH-1:0] ADDR_INTERVAL = CTRL_ADDR_WIDTH'(8'h01);
  localparam logic [CTRL_ADDR_WIDTH-1:0] ADDR_START    = CTRL_ADDR_WIDTH'(8'h02);
  localparam logic [CTRL_ADDR_WIDTH-1:0] ADDR_STOP     = CTRL_ADDR_WIDTH'(8'h03);
  localparam logic [CTRL_ADDR_WIDTH-1:0] ADDR_OVF_CLR  = CTRL_ADDR_WIDTH'(8'h04);

  if (AXI_DATA_WIDTH < PKT_W) begin : g_width_check
    $error("cms_trace_packetizer: AXI_DATA_WIDTH smaller than packet width");
  end

  function automatic logic is_cf(input logic [6:0] opcode);
    case (opcode)
      7'b1101111, 7'b1100111, 7'b1100011: is_cf = 1'b1;
      default:                            is_cf = 1'b0;
    endcase
  endfunction

  logic                   enable_r, drop_wfi_r, cf_only_r, use_trigger_r, we_d_r;
  logic [31:0]            tlast_interval_r, push_cnt_r, overflow_r;
  logic [XLEN-1:0]        start_pc_r, stop_pc_r;
  logic [1:0]             state_r, state_nxt_s;
  logic [PKT_W-1:0]       mem_r [FIFO_DEPTH];
  logic                   last_r [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_r, rd_ptr_r;
  logic [LVL_W-1:0]       level_r;
  logic                   wr_s, eligible_s, capture_s, stop_s, pop_s, full_s;
  logic                   push_ok_s, drop_s, interval_hit_s, enter_drain_s;
  logic [PKT_W-1:0]       pkt_s;

`ifdef CMS_TIMESTAMP_EN
  logic [31:0]            ts_r;

  // Free-running capture timestamp, wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts_r <= 32'd0;
    else     ts_r <= ts_r + 32'd1;
  end
  assign pkt_s = {ts_r, instr, pc};
`else
  assign pkt_s = {instr, pc};
`endif

  assign wr_s = ctrl_write_enable &
                ((CTRL_WRITE_ENABLE_POSEDGE_TRIGGERED != 0) ? ~we_d_r : 1'b1);
  assign eligible_s = pc_valid
                    & ~(drop_wfi_r & (instr == 32'h0000_0001))
                    & ~(cf_only_r & ~is_cf(instr[6:0]));

  assign full_s         = (level_r == LVL_W'(FIFO_DEPTH));
  assign pop_s          = M_AXIS_tvalid & M_AXIS_tready;
  assign push_ok_s      = capture_s & (~full_s | pop_s);
  assign drop_s         = capture_s & full_s & ~pop_s;
  assign interval_hit_s = (tlast_interval_r != 32'd0) && (push_cnt_r == tlast_interval_r - 32'd1);
  assign enter_drain_s  = (state_nxt_s == ST_DRAINING) && (state_r != ST_DRAINING);

  // Capture decision and next-state selection
  always_comb begin
    capture_s   = 1'b0;
    stop_s      = 1'b0;
    state_nxt_s = state_r;
    case (state_r)
      ST_DISABLED: begin
        if (enable_r) state_nxt_s = use_trigger_r ? ST_WAIT_START : ST_CAPTURING;
        else          state_nxt_s = ST_DISABLED;
      end
      ST_WAIT_START: begin
        if (!enable_r) begin
          state_nxt_s = ST_DRAINING;
        end else if (eligible_s && (pc == start_pc_r)) begin
          capture_s   = 1'b1;
          state_nxt_s = ST_CAPTURING;
        end else begin
          state_nxt_s = ST_WAIT_START;
        end
      end
      ST_CAPTURING: begin
        capture_s = eligible_s;
        stop_s    = eligible_s & use_trigger_r & (pc == stop_pc_r);
        if (stop_s || !enable_r) state_nxt_s = ST_DRAINING;
        else                     state_nxt_s = ST_CAPTURING;
      end
      ST_DRAINING: begin
        if (level_r != LVL_W'(1'b0)) state_nxt_s = ST_DRAINING;
        else if (!enable_r)          state_nxt_s = ST_DISABLED;
        else if (use_trigger_r)      state_nxt_s = ST_WAIT_START;
        else                         state_nxt_s = ST_CAPTURING;
      end
      default: state_nxt_s = ST_DISABLED;
    endcase
  end

  // Control register file and overflow counter; a clear beats a same-cycle drop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable_r         <= 1'b0;
      drop_wfi_r       <= 1'b0;
      cf_only_r        <= 1'b0;
      use_trigger_r    <= 1'b0;
      we_d_r           <= 1'b0;
      tlast_interval_r <= 32'd0;
      start_pc_r       <= '0;
      stop_pc_r        <= '0;
      overflow_r       <= 32'd0;
    end else begin
      we_d_r <= ctrl_write_enable;
      if (wr_s) begin
        case (ctrl_addr)
          ADDR_CTRL: begin
            enable_r      <= ctrl_wdata[0];
            drop_wfi_r    <= ctrl_wdata[1];
            cf_only_r     <= ctrl_wdata[2];
            use_trigger_r <= ctrl_wdata[3];
          end
          ADDR_INTERVAL: tlast_interval_r <= 32'(ctrl_wdata);
          ADDR_START:    start_pc_r       <= XLEN'(ctrl_wdata);
          ADDR_STOP:     stop_pc_r        <= XLEN'(ctrl_wdata);
          default: begin
          end
        endcase
      end
      if (wr_s && (ctrl_addr == ADDR_OVF_CLR))            overflow_r <= 32'd0;
      else if (drop_s && (overflow_r != 32'hFFFF_FFFF))   overflow_r <= overflow_r + 32'd1;
    end
  end

  // FSM state and interval push counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_DISABLED;
      push_cnt_r <= 32'd0;
    end else begin
      state_r <= state_nxt_s;
      if (enter_drain_s)  push_cnt_r <= 32'd0;
      else if (push_ok_s) push_cnt_r <= interval_hit_s ? 32'd0 : push_cnt_r + 32'd1;
    end
  end

  // FIFO storage, pointers and occupancy; reset discards contents at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i]  <= '0;
        last_r[i] <= 1'b0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r]  <= pkt_s;
        last_r[wr_ptr_r] <= stop_s | interval_hit_s;
        wr_ptr_r         <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      case ({push_ok_s, pop_s})
        2'b10:   level_r <= level_r + LVL_W'(1'b1);
        2'b01:   level_r <= level_r - LVL_W'(1'b1);
        default: level_r <= level_r;
      endcase
    end
  end

  assign M_AXIS_tvalid  = (level_r != LVL_W'(1'b0));
  assign M_AXIS_tdata   = AXI_DATA_WIDTH'(mem_r[rd_ptr_r]);
  assign M_AXIS_tlast   = M_AXIS_tvalid &
                          (last_r[rd_ptr_r] | ((state_r == ST_DRAINING) && (level_r == LVL_W'(1'b1))));
  assign overflow_count = overflow_r;
  assign fifo_level     = level_r;

endmodule

// File: tb/tb_cms_trace_packetizer.sv
// Self-checking bench for cms_trace_packetizer: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based reference model.
module tb_cms_trace_packetizer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic [63:0] pc;
  logic        pc_valid;
  logic        M_AXIS_tvalid, M_AXIS_tready, M_AXIS_tlast;
  logic [95:0] M_AXIS_tdata;
  logic [7:0]  ctrl_addr;
  logic [63:0] ctrl_wdata;
  logic        ctrl_write_enable;
  logic [31:0] overflow_count;
  logic [4:0]  fifo_level;

  always #5 clk = ~clk;

  cms_trace_packetizer dut (
    .clk(clk), .rst(rst), .instr(instr), .pc(pc), .pc_valid(pc_valid),
    .M_AXIS_tvalid(M_AXIS_tvalid), .M_AXIS_tready(M_AXIS_tready),
    .M_AXIS_tdata(M_AXIS_tdata), .M_AXIS_tlast(M_AXIS_tlast),
    .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata), .ctrl_write_enable(ctrl_write_enable),
    .overflow_count(overflow_count), .fifo_level(fifo_level)
  );

  typedef enum {M_IDLE, M_ARMED, M_RUN, M_FLUSH} mode_t;
  typedef struct { logic [95:0] data; logic last; } ent_t;

  ent_t        q[$];
  mode_t       mode;
  bit          m_en, m_drop_wfi, m_cf_only, m_trig;
  longint      m_interval, m_cnt;
  logic [63:0] m_start, m_stop;
  logic [31:0] m_ovf;
  int          n_total = 0, n_bad = 0;
  int          beats, lasts;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_flow(input logic [31:0] ins);
    return ins[6:0] inside {7'h6f, 7'h67, 7'h63};
  endfunction

  task automatic model_reset();
    q.delete();
    mode = M_IDLE;
    m_en = 0; m_drop_wfi = 0; m_cf_only = 0; m_trig = 0;
    m_interval = 0; m_cnt = 0; m_start = '0; m_stop = '0; m_ovf = '0;
  endtask

  // One clock edge of the reference model, using the inputs currently applied.
  task automatic model_update();
    bit    pop, elig, cap, stp, full, hit, dropped;
    mode_t nxt;
    ent_t  e;
    pop  = (q.size() > 0) && M_AXIS_tready;
    elig = pc_valid && !(m_drop_wfi && instr == 32'h1) && !(m_cf_only && !is_flow(instr));
    cap = 0; stp = 0; dropped = 0; nxt = mode;
    case (mode)
      M_IDLE:  if (m_en) nxt = m_trig ? M_ARMED : M_RUN;
      M_ARMED: if (!m_en) nxt = M_FLUSH;
               else if (elig && pc == m_start) begin cap = 1; nxt = M_RUN; end
      M_RUN: begin
        cap = elig;
        stp = elig && m_trig && (pc == m_stop);
        if (stp || !m_en) nxt = M_FLUSH;
      end
      M_FLUSH: if (q.size() == 0) nxt = !m_en ? M_IDLE : (m_trig ? M_ARMED : M_RUN);
      default: nxt = M_IDLE;
    endcase
    full = (q.size() >= 16);
    if (pop) e = q.pop_front();
    if (cap) begin
      if (!full || pop) begin
        hit = (m_interval != 0) && (m_cnt + 1 == m_interval);
        e.data = {instr, pc};
        e.last = stp || hit;
        q.push_back(e);
        m_cnt = hit ? 0 : m_cnt + 1;
      end else begin
        dropped = 1;
      end
    end
    if (nxt == M_FLUSH && mode != M_FLUSH) m_cnt = 0;
    if (ctrl_write_enable && ctrl_addr == 8'h04) m_ovf = 0;
    else if (dropped && m_ovf != 32'hFFFF_FFFF) m_ovf = m_ovf + 1;
    if (ctrl_write_enable) begin
      case (ctrl_addr)
        8'h00: begin m_en = ctrl_wdata[0]; m_drop_wfi = ctrl_wdata[1];
                     m_cf_only = ctrl_wdata[2]; m_trig = ctrl_wdata[3]; end
        8'h01: m_interval = longint'(ctrl_wdata[31:0]);
        8'h02: m_start = ctrl_wdata;
        8'h03: m_stop = ctrl_wdata;
        default: ;
      endcase
    end
    mode = nxt;
  endtask

  // Compare outputs mid-cycle, then advance model and DUT by one edge.
  task automatic cycle();
    @(negedge clk);
    chk("tvalid", M_AXIS_tvalid, q.size() != 0);
    chk("fifo_level", fifo_level, q.size());
    chk("overflow_count", overflow_count, m_ovf);
    if (q.size() != 0) begin
      chk("tdata", M_AXIS_tdata, q[0].data);
      chk("tlast", M_AXIS_tlast, q[0].last || (mode == M_FLUSH && q.size() == 1));
    end
    if (M_AXIS_tvalid && M_AXIS_tready) begin
      beats++;
      if (M_AXIS_tlast) lasts++;
    end
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit pv, input logic [31:0] ins, input logic [63:0] p, input bit rdy,
                       input bit we, input logic [7:0] a, input logic [63:0] d);
    pc_valid = pv; instr = ins; pc = p; M_AXIS_tready = rdy;
    ctrl_write_enable = we; ctrl_addr = a; ctrl_wdata = d;
    cycle();
  endtask

  task automatic wr(input logic [7:0] a, input logic [63:0] d, input bit rdy);
    drive(0, 32'h0, 64'h0, rdy, 1, a, d);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) drive(0, 32'h0, 64'h0, rdy, 0, 8'h0, 64'h0);
  endtask

  task automatic cap(input logic [31:0] ins, input logic [63:0] p, input bit rdy);
    drive(1, ins, p, rdy, 0, 8'h0, 64'h0);
  endtask

  task automatic drain_all();
    int k;
    wr(8'h00, 64'h0, 1);
    k = 0;
    while ((q.size() != 0 || mode != M_IDLE) && k < 100) begin
      idle(1, 1);
      k++;
    end
    chk("drain_bound", q.size(), 0);
  endtask

  initial begin
    logic [31:0] ins_tab [6];
    logic [31:0] ri;
    ins_tab = '{32'h0000_0013, 32'h0000_006f, 32'h0C60_1063, 32'h0000_0067, 32'h0000_0001, 32'h0000_00ef};
    rst = 1'b1; pc_valid = 0; instr = 0; pc = 0; M_AXIS_tready = 0;
    ctrl_write_enable = 0; ctrl_addr = 0; ctrl_wdata = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", M_AXIS_tvalid, 0);
    chk("rst_tdata", M_AXIS_tdata, 0);
    chk("rst_tlast", M_AXIS_tlast, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovf", overflow_count, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Interval tlast every 4 captures
    wr(8'h01, 64'd4, 1); wr(8'h00, 64'h1, 1); idle(1, 1);
    beats = 0; lasts = 0;
    for (int i = 0; i < 8; i++) cap($urandom, 64'(8 + 4 * i), 1);
    idle(4, 1);
    chk("p1_beats", beats, 8);
    chk("p1_lasts", lasts, 2);

    // PC-range trigger, run twice to show re-arming
    drain_all();
    wr(8'h01, 64'd0, 1); wr(8'h02, 64'h20, 1); wr(8'h03, 64'h30, 1); wr(8'h00, 64'h9, 1); idle(1, 1);
    beats = 0; lasts = 0;
    for (int r = 0; r < 2; r++) begin
      for (int p = 'h10; p <= 'h40; p += 4) cap($urandom, 64'(p), 1);
      idle(4, 1);
    end
    chk("p2_beats", beats, 10);
    chk("p2_lasts", lasts, 2);

    // Overflow, full-with-pop push, clear racing an overflow
    drain_all();
    wr(8'h00, 64'h1, 0); idle(1, 0);
    for (int i = 0; i < 20; i++) cap($urandom, 64'(32'h1000 + 4 * i), 0);
    chk("p3_level", fifo_level, 16);
    chk("p3_ovf", overflow_count, 4);
    cap($urandom, 64'h2000, 1);
    chk("p3_fullpop_level", fifo_level, 16);
    chk("p3_fullpop_ovf", overflow_count, 4);
    drive(1, $urandom, 64'h2004, 0, 1, 8'h04, 64'h0);
    chk("p3_clear_wins", overflow_count, 0);
    cap($urandom, 64'h2008, 0);
    wr(8'h04, 64'h0, 0);
    chk("p3_clear", overflow_count, 0);
    beats = 0;
    idle(20, 1);
    chk("p3_beats", beats, 16);

    // Instruction-class filtering
    drain_all();
    wr(8'h00, 64'h7, 1); idle(1, 1);
    beats = 0;
    cap(32'h0000_0013, 64'h200, 1); cap(32'h0000_006f, 64'h204, 1);
    cap(32'h0C60_1063, 64'h208, 1); cap(32'h0000_0067, 64'h20c, 1);
    cap(32'h0000_0001, 64'h210, 1); cap(32'h0000_00ef, 64'h214, 1);
    cap(32'h0013_0013, 64'h218, 1);
    idle(3, 1);
    chk("p4_beats", beats, 4);

    // Controlled drain with forced tlast
    drain_all();
    wr(8'h01, 64'd100, 0); wr(8'h00, 64'h1, 0); idle(1, 0);
    for (int i = 0; i < 3; i++) cap($urandom, 64'(32'h300 + 4 * i), 0);
    wr(8'h00, 64'h0, 0); idle(1, 0);
    for (int i = 0; i < 3; i++) cap($urandom, 64'(32'h400 + 4 * i), 0);
    chk("p5_level", fifo_level, 3);
    beats = 0; lasts = 0;
    idle(5, 1);
    chk("p5_beats", beats, 3);
    chk("p5_lasts", lasts, 1);
    for (int i = 0; i < 3; i++) cap($urandom, 64'(32'h500 + 4 * i), 1);
    chk("p5_disabled", fifo_level, 0);

    // Randomized traffic
    for (int r = 0; r < 8; r++) begin
      drain_all();
      wr(8'h01, 64'($urandom_range(0, 5)), 1);
      wr(8'h02, 64'(32'h100 + 4 * $urandom_range(0, 7)), 1);
      wr(8'h03, 64'(32'h100 + 4 * $urandom_range(0, 7)), 1);
      wr(8'h00, {60'h0, 4'($urandom_range(0, 15)) | 4'h1}, 1);
      idle(1, 1);
      for (int i = 0; i < 80; i++) begin
        ri = ($urandom_range(0, 3) == 0) ? $urandom : ins_tab[$urandom_range(0, 5)];
        drive($urandom_range(0, 9) < 7, ri, 64'(32'h100 + 4 * $urandom_range(0, 7)),
              (r % 3 == 2) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0),
              $urandom_range(0, 31) == 0, 8'h04, 64'h0);
      end
    end

    // Asynchronous reset mid-stream
    drain_all();
    wr(8'h00, 64'h1, 0); idle(1, 0);
    for (int i = 0; i < 5; i++) cap($urandom, 64'(32'h600 + 4 * i), 0);
    rst = 1'b1;
    #2;
    chk("arst_tvalid", M_AXIS_tvalid, 0);
    chk("arst_level", fifo_level, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cap($urandom, 64'(32'h700 + 4 * i), 1);
    chk("arst_noenable", fifo_level, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
